// File: rtl/parity_counter_monitor.sv
// Receive-side checker for the 3-bit parity counter display interface.
// Decodes the active-low 7-segment pattern, cross-checks it against the
// counter's binary value and against the step expected for the counter mode,
// and reports error pulses, a saturating error count and a lock status.
module parity_counter_monitor #(
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [6:0]       LED_7SEG,
    input  logic [2:0]       Q,
    input  logic             EVEN,
    input  logic             ODD,
    input  logic             PAUSE,
    input  logic             CLR_IN,
    output logic [2:0]       DIGIT,
    output logic             DIGIT_VALID,
    output logic             SEG_ERR,
    output logic             Q_ERR,
    output logic             SEQ_ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             STICKY_ERR,
    output logic             LOCKED
);

    localparam int unsigned GOOD_W = 4;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_nxt;

    // Controls of the previous sample; they define the step into this one.
    logic ctrl_even;
    logic ctrl_odd;
    logic ctrl_pause;
    logic ctrl_clr;

    logic       seg_legal_c;
    logic [2:0] seg_digit_c;
    logic [2:0] exp_digit_c;
    logic       q_err_c;
    logic       seq_err_c;
    logic       any_err_c;

    // Active-low segment pattern to digit; anything off-table is illegal.
    always_comb begin
        seg_legal_c = 1'b1;
        seg_digit_c = 3'd0;
        case (LED_7SEG)
            7'b1000000: seg_digit_c = 3'd0;
            7'b1111001: seg_digit_c = 3'd1;
            7'b0100100: seg_digit_c = 3'd2;
            7'b0110000: seg_digit_c = 3'd3;
            7'b0011001: seg_digit_c = 3'd4;
            7'b0010010: seg_digit_c = 3'd5;
            7'b0000010: seg_digit_c = 3'd6;
            7'b1111000: seg_digit_c = 3'd7;
            default:    seg_legal_c = 1'b0;
        endcase
    end

    // Expected digit from the reference digit and the previous controls; 3-bit wrap gives mod 8.
    always_comb begin
        exp_digit_c = DIGIT + 3'd1;
        if (ctrl_clr) begin
            exp_digit_c = (ctrl_odd && !ctrl_even) ? 3'd1 : 3'd0;
        end else if (ctrl_pause) begin
            exp_digit_c = DIGIT;
        end else if (ctrl_odd && !ctrl_even) begin
            exp_digit_c = DIGIT[0] ? (DIGIT + 3'd2) : (DIGIT + 3'd1);
        end else if (ctrl_even && !ctrl_odd) begin
            exp_digit_c = DIGIT[0] ? (DIGIT + 3'd1) : (DIGIT + 3'd2);
        end
    end

    // Per-sample error classification.
    always_comb begin
        q_err_c   = seg_legal_c && (seg_digit_c != Q);
        seq_err_c = seg_legal_c && (state != ST_SYNC) && (seg_digit_c != exp_digit_c);
        any_err_c = !seg_legal_c || q_err_c || seq_err_c;
    end

    // Lock FSM next state and good-sample counter.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        if (!seg_legal_c) begin
            state_nxt    = ST_SYNC;
            good_cnt_nxt = '0;
        end else begin
            case (state)
                ST_SYNC: begin
                    state_nxt    = ST_ACQUIRE;
                    good_cnt_nxt = '0;
                end
                ST_ACQUIRE: begin
                    if (q_err_c || seq_err_c) begin
                        good_cnt_nxt = '0;
                    end else if ((good_cnt + GOOD_W'(1)) == GOOD_W'(LOCK_N)) begin
                        state_nxt    = ST_LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (q_err_c || seq_err_c) begin
                        state_nxt    = ST_ACQUIRE;
                        good_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_SYNC;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Sample registers, error pulses, counters and status.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_SYNC;
            good_cnt    <= '0;
            ctrl_even   <= 1'b0;
            ctrl_odd    <= 1'b0;
            ctrl_pause  <= 1'b0;
            ctrl_clr    <= 1'b0;
            DIGIT       <= 3'd0;
            DIGIT_VALID <= 1'b0;
            SEG_ERR     <= 1'b0;
            Q_ERR       <= 1'b0;
            SEQ_ERR     <= 1'b0;
            ERR_CNT     <= '0;
            STICKY_ERR  <= 1'b0;
            LOCKED      <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            ctrl_even  <= EVEN;
            ctrl_odd   <= ODD;
            ctrl_pause <= PAUSE;
            ctrl_clr   <= CLR_IN;
            // The observed digit is also the next reference, which resynchronises after SEQ_ERR.
            if (seg_legal_c) begin
                DIGIT <= seg_digit_c;
            end
            DIGIT_VALID <= seg_legal_c;
            SEG_ERR     <= !seg_legal_c;
            Q_ERR       <= q_err_c;
            SEQ_ERR     <= seq_err_c;
            if (any_err_c && (ERR_CNT != {CNT_W{1'b1}})) begin
                ERR_CNT <= ERR_CNT + CNT_W'(1);
            end
            if (any_err_c) begin
                STICKY_ERR <= 1'b1;
            end
            LOCKED <= (state_nxt == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_parity_counter_monitor.sv
// Testbench for parity_counter_monitor: directed table plus randomized
// stimulus against a behavioural model; a second instance with a 2-bit
// error counter covers saturation.
module tb_parity_counter_monitor;

    localparam int LOCK_N = 4;

    logic       CLK;
    logic       RESET;
    logic [6:0] LED_7SEG;
    logic [2:0] Q;
    logic       EVEN;
    logic       ODD;
    logic       PAUSE;
    logic       CLR_IN;

    logic [2:0] DIGIT;
    logic       DIGIT_VALID;
    logic       SEG_ERR;
    logic       Q_ERR;
    logic       SEQ_ERR;
    logic [7:0] ERR_CNT;
    logic       STICKY_ERR;
    logic       LOCKED;

    logic [2:0] s_digit;
    logic       s_valid;
    logic       s_seg_err;
    logic       s_q_err;
    logic       s_seq_err;
    logic [1:0] s_err_cnt;
    logic       s_sticky;
    logic       s_locked;

    parity_counter_monitor #(.LOCK_N(LOCK_N), .CNT_W(8)) u_dut (
        .CLK(CLK), .RESET(RESET), .LED_7SEG(LED_7SEG), .Q(Q),
        .EVEN(EVEN), .ODD(ODD), .PAUSE(PAUSE), .CLR_IN(CLR_IN),
        .DIGIT(DIGIT), .DIGIT_VALID(DIGIT_VALID), .SEG_ERR(SEG_ERR),
        .Q_ERR(Q_ERR), .SEQ_ERR(SEQ_ERR), .ERR_CNT(ERR_CNT),
        .STICKY_ERR(STICKY_ERR), .LOCKED(LOCKED)
    );

    parity_counter_monitor #(.LOCK_N(LOCK_N), .CNT_W(2)) u_sat (
        .CLK(CLK), .RESET(RESET), .LED_7SEG(LED_7SEG), .Q(Q),
        .EVEN(EVEN), .ODD(ODD), .PAUSE(PAUSE), .CLR_IN(CLR_IN),
        .DIGIT(s_digit), .DIGIT_VALID(s_valid), .SEG_ERR(s_seg_err),
        .Q_ERR(s_q_err), .SEQ_ERR(s_seq_err), .ERR_CNT(s_err_cnt),
        .STICKY_ERR(s_sticky), .LOCKED(s_locked)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Control nibble order: {EVEN, ODD, PAUSE, CLR_IN}
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_ODD  = 4'b0100;
    localparam logic [3:0] C_EV   = 4'b1000;
    localparam logic [3:0] C_EVP  = 4'b1010;
    localparam logic [3:0] C_EVC  = 4'b1001;

    typedef struct {
        int         dig;
        bit         ill;
        int         q;
        logic [3:0] ctrl;
        int         e_digit;
        int         e_valid;
        int         e_seg;
        int         e_q;
        int         e_seq;
        int         e_locked;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] seg_tab[8];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state
    int m_digit, m_valid, m_state, m_good, m_cnt, m_sat, m_sticky, m_locked;
    int e_seg, e_q, e_seq;
    bit mc_even, mc_odd, mc_pause, mc_clr;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 8; i++) if (s == seg_tab[i]) return i;
        return -1;
    endfunction

    // Next counter value from the counter's documented stepping rules.
    function automatic int nxt(input int p, input bit ev, input bit od, input bit pa, input bit cl);
        if (cl) return (od && !ev) ? 1 : 0;
        if (pa) return p;
        if (od && !ev) return (p % 2 == 1) ? (p + 2) % 8 : p + 1;
        if (ev && !od) return (p % 2 == 0) ? (p + 2) % 8 : (p + 1) % 8;
        return (p + 1) % 8;
    endfunction

    task automatic model_reset();
        m_digit = 0; m_valid = 0; m_state = 0; m_good = 0;
        m_cnt = 0; m_sat = 0; m_sticky = 0; m_locked = 0;
        e_seg = 0; e_q = 0; e_seq = 0;
        mc_even = 0; mc_odd = 0; mc_pause = 0; mc_clr = 0;
    endtask

    // States: 0 = SYNC, 1 = ACQUIRE, 2 = LOCKED
    task automatic model_step();
        int d;
        int exp_n;
        d     = dec(LED_7SEG);
        exp_n = nxt(m_digit, mc_even, mc_odd, mc_pause, mc_clr);
        e_seg = (d < 0) ? 1 : 0;
        e_q   = (d >= 0 && d != int'(Q)) ? 1 : 0;
        e_seq = (d >= 0 && m_state != 0 && d != exp_n) ? 1 : 0;
        if (e_seg + e_q + e_seq > 0) begin
            if (m_cnt < 255) m_cnt++;
            if (m_sat < 3) m_sat++;
            m_sticky = 1;
        end
        if (d < 0) begin
            m_state = 0; m_good = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_good = 0;
        end else if (e_q + e_seq > 0) begin
            m_state = 1; m_good = 0;
        end else if (m_state == 1) begin
            m_good++;
            if (m_good == LOCK_N) begin
                m_state = 2; m_good = 0;
            end
        end
        if (d >= 0) m_digit = d;
        m_valid  = (d >= 0) ? 1 : 0;
        m_locked = (m_state == 2) ? 1 : 0;
        mc_even = EVEN; mc_odd = ODD; mc_pause = PAUSE; mc_clr = CLR_IN;
    endtask

    task automatic check_model();
        chk("digit",      int'(DIGIT),       m_digit);
        chk("valid",      int'(DIGIT_VALID), m_valid);
        chk("seg_err",    int'(SEG_ERR),     e_seg);
        chk("q_err",      int'(Q_ERR),       e_q);
        chk("seq_err",    int'(SEQ_ERR),     e_seq);
        chk("err_cnt",    int'(ERR_CNT),     m_cnt);
        chk("sticky",     int'(STICKY_ERR),  m_sticky);
        chk("locked",     int'(LOCKED),      m_locked);
        chk("sat_digit",  int'(s_digit),     m_digit);
        chk("sat_valid",  int'(s_valid),     m_valid);
        chk("sat_seg",    int'(s_seg_err),   e_seg);
        chk("sat_q",      int'(s_q_err),     e_q);
        chk("sat_seq",    int'(s_seq_err),   e_seq);
        chk("sat_cnt",    int'(s_err_cnt),   m_sat);
        chk("sat_sticky", int'(s_sticky),    m_sticky);
        chk("sat_locked", int'(s_locked),    m_locked);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digit"},   int'(DIGIT),       0);
        chk({tag, "_valid"},   int'(DIGIT_VALID), 0);
        chk({tag, "_seg"},     int'(SEG_ERR),     0);
        chk({tag, "_q"},       int'(Q_ERR),       0);
        chk({tag, "_seq"},     int'(SEQ_ERR),     0);
        chk({tag, "_cnt"},     int'(ERR_CNT),     0);
        chk({tag, "_sticky"},  int'(STICKY_ERR),  0);
        chk({tag, "_locked"},  int'(LOCKED),      0);
        chk({tag, "_sat_cnt"}, int'(s_err_cnt),   0);
        chk({tag, "_sat_stk"}, int'(s_sticky),    0);
    endtask

    // One sample: inputs set on the falling edge, captured on the rising edge, checked 1 ns later.
    task automatic drive(input logic [6:0] seg, input int q, input logic [3:0] ctrl);
        @(negedge CLK);
        LED_7SEG = seg;
        Q        = 3'(q);
        {EVEN, ODD, PAUSE, CLR_IN} = ctrl;
        @(posedge CLK);
        model_step();
        #1;
        check_model();
    endtask

    task automatic add(input int dig, input bit ill, input int q, input logic [3:0] ctrl,
                       input int ed, input int ev, input int es, input int eq,
                       input int eqs, input int el);
        vec_t v;
        v.dig = dig; v.ill = ill; v.q = q; v.ctrl = ctrl;
        v.e_digit = ed; v.e_valid = ev; v.e_seg = es; v.e_q = eq;
        v.e_seq = eqs; v.e_locked = el;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0] seg;
        logic [3:0] ctrl;
        int         d;
        int         q;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;

        // Free count 0..7..0, lock after 1+LOCK_N samples
        for (int i = 0; i < 9; i++) add(i % 8, 0, i % 8, C_NONE, i % 8, 1, 0, 0, 0, (i >= 4) ? 1 : 0);
        // ODD sequence, injected 4 instead of 3, relock
        add(1, 0, 1, C_ODD, 1, 1, 0, 0, 0, 1);
        add(3, 0, 3, C_ODD, 3, 1, 0, 0, 0, 1);
        add(5, 0, 5, C_ODD, 5, 1, 0, 0, 0, 1);
        add(7, 0, 7, C_ODD, 7, 1, 0, 0, 0, 1);
        add(1, 0, 1, C_ODD, 1, 1, 0, 0, 0, 1);
        add(4, 0, 4, C_ODD, 4, 1, 0, 0, 1, 0);
        add(5, 0, 5, C_ODD, 5, 1, 0, 0, 0, 0);
        add(7, 0, 7, C_ODD, 7, 1, 0, 0, 0, 0);
        add(1, 0, 1, C_ODD, 1, 1, 0, 0, 0, 0);
        add(3, 0, 3, C_ODD, 3, 1, 0, 0, 0, 1);
        // EVEN with PAUSE held at 4, then CLR
        add(5, 0, 5, C_EV,  5, 1, 0, 0, 0, 1);
        add(6, 0, 6, C_EV,  6, 1, 0, 0, 0, 1);
        add(0, 0, 0, C_EV,  0, 1, 0, 0, 0, 1);
        add(2, 0, 2, C_EV,  2, 1, 0, 0, 0, 1);
        add(4, 0, 4, C_EVP, 4, 1, 0, 0, 0, 1);
        add(4, 0, 4, C_EVP, 4, 1, 0, 0, 0, 1);
        add(4, 0, 4, C_EV,  4, 1, 0, 0, 0, 1);
        add(6, 0, 6, C_EVC, 6, 1, 0, 0, 0, 1);
        add(0, 0, 0, C_EV,  0, 1, 0, 0, 0, 1);
        add(2, 0, 2, C_EVC, 2, 1, 0, 0, 0, 1);
        add(2, 0, 2, C_EV,  2, 1, 0, 0, 1, 0);
        // Illegal pattern, then resync without SEQ_ERR
        add(0, 1, 4, C_NONE, 2, 0, 1, 0, 0, 0);
        add(7, 0, 7, C_NONE, 7, 1, 0, 0, 0, 0);
        // Relock, then Q mismatch only
        add(0, 0, 0, C_NONE, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, C_NONE, 1, 1, 0, 0, 0, 0);
        add(2, 0, 2, C_NONE, 2, 1, 0, 0, 0, 0);
        add(3, 0, 3, C_NONE, 3, 1, 0, 0, 0, 1);
        add(4, 0, 4, C_NONE, 4, 1, 0, 0, 0, 1);
        add(5, 0, 3, C_NONE, 5, 1, 0, 1, 0, 0);
        add(6, 0, 6, C_NONE, 6, 1, 0, 0, 0, 0);

        RESET = 1'b1; LED_7SEG = 7'h7F; Q = 3'd0;
        EVEN = 1'b0; ODD = 1'b0; PAUSE = 1'b0; CLR_IN = 1'b0;
        model_reset();
        #12;
        check_zero("rst");
        @(posedge CLK);
        #1 RESET = 1'b0;

        foreach (vecs[i]) begin
            seg = vecs[i].ill ? 7'h7F : seg_tab[vecs[i].dig];
            drive(seg, vecs[i].q, vecs[i].ctrl);
            chk($sformatf("vec%0d_digit", i),  int'(DIGIT),       vecs[i].e_digit);
            chk($sformatf("vec%0d_valid", i),  int'(DIGIT_VALID), vecs[i].e_valid);
            chk($sformatf("vec%0d_seg", i),    int'(SEG_ERR),     vecs[i].e_seg);
            chk($sformatf("vec%0d_q", i),      int'(Q_ERR),       vecs[i].e_q);
            chk($sformatf("vec%0d_seq", i),    int'(SEQ_ERR),     vecs[i].e_seq);
            chk($sformatf("vec%0d_locked", i), int'(LOCKED),      vecs[i].e_locked);
        end
        // Four erroneous samples so far: full counter 4, 2-bit counter saturated
        chk("dir_err_cnt", int'(ERR_CNT),    4);
        chk("dir_sat_cnt", int'(s_err_cnt),  3);
        chk("dir_sticky",  int'(STICKY_ERR), 1);

        // Randomized stimulus, mostly on-sequence to let the monitor lock
        for (int i = 0; i < 300; i++) begin
            ctrl[3] = 1'($urandom_range(0, 1));
            ctrl[2] = 1'($urandom_range(0, 1));
            ctrl[1] = ($urandom_range(0, 4) == 0);
            ctrl[0] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 8) d = nxt(m_digit, mc_even, mc_odd, mc_pause, mc_clr);
            else d = int'($urandom_range(0, 7));
            q   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : d;
            seg = ($urandom_range(0, 19) == 0) ? 7'($urandom) : seg_tab[d];
            drive(seg, q, ctrl);
        end

        // Asynchronous reset between edges clears everything at once
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ctrl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) d = nxt(m_digit, mc_even, mc_odd, mc_pause, mc_clr);
            else d = int'($urandom_range(0, 7));
            q = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : d;
            drive(seg_tab[d], q, ctrl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
